// File: rtl/bp_sacc_host_driver.sv
// Host-side driver for a streaming accelerator tile: programs the job CSRs over the BedRock
// I/O memory interface, starts the job, polls status and hands the result back to the requester.
module bp_sacc_host_driver
  #(parameter int          paddr_width_p  = 40
   ,parameter int          lce_id_width_p = 8
   ,parameter int          did_width_p    = 4
   ,parameter logic [63:0] csr_base_p     = 64'h0
   ,parameter int          poll_gap_p     = 8
   ,parameter int          poll_limit_p   = 1024
   ,localparam int         hdr_width_lp   = 4 + 4 + paddr_width_p + 3 + did_width_p + lce_id_width_p
   )
  (input  logic                      clk_i
   ,input  logic                      reset_i
   ,input  logic [lce_id_width_p-1:0] lce_id_i
   ,input  logic                      job_v_i
   ,output logic                      job_ready_and_o
   ,input  logic [63:0]               job_a_i
   ,input  logic [63:0]               job_b_i
   ,input  logic [63:0]               job_len_i
   ,output logic [hdr_width_lp-1:0]   io_cmd_header_o
   ,output logic [63:0]               io_cmd_data_o
   ,output logic                      io_cmd_v_o
   ,input  logic                      io_cmd_ready_and_i
   ,input  logic [hdr_width_lp-1:0]   io_resp_header_i
   ,input  logic [63:0]               io_resp_data_i
   ,input  logic                      io_resp_v_i
   ,output logic                      io_resp_yumi_o
   ,output logic [63:0]               result_o
   ,output logic                      result_err_o
   ,output logic                      result_v_o
   ,input  logic                      result_yumi_i
   );

   // Header layout, MSB first: msg_type[4] subop[4] addr[paddr] size[3] payload{did, lce_id}
   localparam logic [3:0] mem_uc_rd_lp  = 4'b0010;
   localparam logic [3:0] mem_uc_wr_lp  = 4'b0011;
   localparam logic [2:0] msg_size_8_lp = 3'b011;

   localparam int gap_width_lp  = (poll_gap_p > 0) ? $clog2(poll_gap_p + 1) : 1;
   localparam int poll_width_lp = $clog2(poll_limit_p + 1);
   localparam logic [gap_width_lp-1:0]  gap_last_lp  = gap_width_lp'((poll_gap_p > 0) ? poll_gap_p - 1 : 0);
   localparam logic [poll_width_lp-1:0] poll_last_lp = poll_width_lp'(poll_limit_p - 1);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_WR_A       = 4'd1;
   localparam logic [3:0] S_WAIT_A     = 4'd2;
   localparam logic [3:0] S_WR_B       = 4'd3;
   localparam logic [3:0] S_WAIT_B     = 4'd4;
   localparam logic [3:0] S_WR_LEN     = 4'd5;
   localparam logic [3:0] S_WAIT_LEN   = 4'd6;
   localparam logic [3:0] S_WR_START   = 4'd7;
   localparam logic [3:0] S_WAIT_START = 4'd8;
   localparam logic [3:0] S_RD_STAT    = 4'd9;
   localparam logic [3:0] S_WAIT_STAT  = 4'd10;
   localparam logic [3:0] S_GAP        = 4'd11;
   localparam logic [3:0] S_RD_RES     = 4'd12;
   localparam logic [3:0] S_WAIT_RES   = 4'd13;
   localparam logic [3:0] S_DONE       = 4'd14;

   logic [3:0]               state_q, state_d;
   logic [63:0]              a_q, a_d, b_q, b_d, len_q, len_d, result_q, result_d;
   logic                     err_q, err_d, drain_q, drain_d;
   logic [poll_width_lp-1:0] poll_q, poll_d;
   logic [gap_width_lp-1:0]  gap_q, gap_d;
   logic                     cmd_fire, in_wait;
   logic [3:0]               cmd_type, resp_type_exp;
   logic [7:0]               cmd_offset;
   logic [paddr_width_p-1:0] cmd_addr;
   logic                     unused_resp_hdr;

   // Command channel is decoded purely from state so valid never depends on ready.
   always_comb begin
      io_cmd_v_o    = 1'b0;
      cmd_type      = mem_uc_wr_lp;
      cmd_offset    = 8'h00;
      io_cmd_data_o = '0;
      case (state_q)
         S_WR_A:     begin io_cmd_v_o = 1'b1; cmd_offset = 8'h00; io_cmd_data_o = a_q;   end
         S_WR_B:     begin io_cmd_v_o = 1'b1; cmd_offset = 8'h08; io_cmd_data_o = b_q;   end
         S_WR_LEN:   begin io_cmd_v_o = 1'b1; cmd_offset = 8'h10; io_cmd_data_o = len_q; end
         S_WR_START: begin io_cmd_v_o = 1'b1; cmd_offset = 8'h18; io_cmd_data_o = 64'd1; end
         S_RD_STAT:  begin io_cmd_v_o = 1'b1; cmd_offset = 8'h20; cmd_type = mem_uc_rd_lp; end
         S_RD_RES:   begin io_cmd_v_o = 1'b1; cmd_offset = 8'h28; cmd_type = mem_uc_rd_lp; end
         default:    ;
      endcase
   end

   assign cmd_addr        = csr_base_p[paddr_width_p-1:0] + paddr_width_p'(cmd_offset);
   assign io_cmd_header_o = io_cmd_v_o
                          ? {cmd_type, 4'b0000, cmd_addr, msg_size_8_lp, {did_width_p{1'b0}}, lce_id_i}
                          : '0;
   assign cmd_fire        = io_cmd_v_o & io_cmd_ready_and_i;

   assign in_wait = (state_q == S_WAIT_A)   || (state_q == S_WAIT_B)     || (state_q == S_WAIT_LEN)
                 || (state_q == S_WAIT_START) || (state_q == S_WAIT_STAT) || (state_q == S_WAIT_RES);

   // drain_q swallows responses orphaned by a reset until the first new command goes out
   assign io_resp_yumi_o  = io_resp_v_i & (in_wait | drain_q);
   assign job_ready_and_o = (state_q == S_IDLE);
   assign result_v_o      = (state_q == S_DONE);
   assign result_o        = result_q;
   assign result_err_o    = err_q;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      len_d    = len_q;
      result_d = result_q;
      err_d    = err_q;
      poll_d   = poll_q;
      gap_d    = gap_q;
      drain_d  = drain_q & ~cmd_fire;
      case (state_q)
         S_IDLE: if (job_v_i) begin
            a_d     = job_a_i;
            b_d     = job_b_i;
            len_d   = job_len_i;
            state_d = S_WR_A;
         end
         S_WR_A:       if (cmd_fire)    state_d = S_WAIT_A;
         S_WAIT_A:     if (io_resp_v_i) state_d = S_WR_B;
         S_WR_B:       if (cmd_fire)    state_d = S_WAIT_B;
         S_WAIT_B:     if (io_resp_v_i) state_d = S_WR_LEN;
         S_WR_LEN:     if (cmd_fire)    state_d = S_WAIT_LEN;
         S_WAIT_LEN:   if (io_resp_v_i) state_d = S_WR_START;
         S_WR_START:   if (cmd_fire)    state_d = S_WAIT_START;
         S_WAIT_START: if (io_resp_v_i) state_d = S_RD_STAT;
         S_RD_STAT:    if (cmd_fire)    state_d = S_WAIT_STAT;
         S_WAIT_STAT: if (io_resp_v_i) begin
            if (io_resp_data_i != '0) begin
               state_d = S_RD_RES;
            end else if (poll_q == poll_last_lp) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = S_DONE;
            end else begin
               if (poll_q != '1) poll_d = poll_q + 1'b1;
               gap_d   = '0;
               state_d = (poll_gap_p == 0) ? S_RD_STAT : S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == gap_last_lp) state_d = S_RD_STAT;
            else                      gap_d   = gap_q + 1'b1;
         end
         S_RD_RES:     if (cmd_fire)    state_d = S_WAIT_RES;
         S_WAIT_RES: if (io_resp_v_i) begin
            result_d = io_resp_data_i;
            err_d    = 1'b0;
            state_d  = S_DONE;
         end
         S_DONE: if (result_yumi_i) begin
            poll_d  = '0;
            gap_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         len_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         poll_q   <= '0;
         gap_q    <= '0;
         drain_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         len_q    <= len_d;
         result_q <= result_d;
         err_q    <= err_d;
         poll_q   <= poll_d;
         gap_q    <= gap_d;
         drain_q  <= drain_d;
      end
   end

   assign resp_type_exp   = ((state_q == S_WAIT_STAT) || (state_q == S_WAIT_RES)) ? mem_uc_rd_lp : mem_uc_wr_lp;
   assign unused_resp_hdr = ^io_resp_header_i;

   resp_type_match: assert property (@(posedge clk_i) disable iff (reset_i)
      (io_resp_v_i && in_wait) |-> (io_resp_header_i[hdr_width_lp-1 -: 4] == resp_type_exp));

endmodule

// File: tb/tb_bp_sacc_host_driver.sv
// Scoreboard bench for bp_sacc_host_driver: a responder model plays the accelerator CSRs,
// expected commands/results are queued at job issue and checked as the DUT presents them.
`timescale 1ns/1ps
module tb_bp_sacc_host_driver;
   localparam int PA = 40, LW = 8, DW = 4, HW = 4 + 4 + PA + 3 + DW + LW;
   localparam int GAP = 8, LIMIT = 4;
   localparam logic [63:0] BASE  = 64'h20_0000;
   localparam logic [3:0]  UC_RD = 4'h2, UC_WR = 4'h3;
   localparam logic [7:0]  LCE   = 8'h5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i, job_v_i, job_ready_and_o;
   logic [63:0]   job_a_i, job_b_i, job_len_i;
   logic [HW-1:0] io_cmd_header_o, io_resp_header_i;
   logic [63:0]   io_cmd_data_o, io_resp_data_i, result_o;
   logic          io_cmd_v_o, io_cmd_ready_and_i, io_resp_v_i, io_resp_yumi_o;
   logic          result_err_o, result_v_o, result_yumi_i;

   bp_sacc_host_driver #(
      .paddr_width_p(PA), .lce_id_width_p(LW), .did_width_p(DW),
      .csr_base_p(BASE), .poll_gap_p(GAP), .poll_limit_p(LIMIT)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .lce_id_i(LCE),
      .job_v_i(job_v_i), .job_ready_and_o(job_ready_and_o),
      .job_a_i(job_a_i), .job_b_i(job_b_i), .job_len_i(job_len_i),
      .io_cmd_header_o(io_cmd_header_o), .io_cmd_data_o(io_cmd_data_o),
      .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
      .io_resp_header_i(io_resp_header_i), .io_resp_data_i(io_resp_data_i),
      .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
      .result_o(result_o), .result_err_o(result_err_o),
      .result_v_o(result_v_o), .result_yumi_i(result_yumi_i)
   );

   typedef struct packed { logic [HW-1:0] hdr; logic [63:0] data; } cmd_t;
   typedef struct packed { logic [63:0] val; logic err; } res_t;

   cmd_t        exp_cmd_q[$];
   res_t        exp_res_q[$];
   logic [63:0] stat_q[$];
   logic [63:0] res_data_q[$];

   int n_checks = 0, n_fail = 0;
   bit bp_mode = 0, hold_stat = 0;
   int n_stat_fire = 0, n_resp_done = 0;
   logic [PA-1:0] stat_addr, res_addr;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endfunction

   function automatic cmd_t mk_cmd(input logic [3:0] t, input logic [7:0] off, input logic [63:0] d);
      cmd_t c;
      logic [PA-1:0] addr;
      addr   = BASE[PA-1:0] + {32'h0, off};
      c.hdr  = {t, 4'h0, addr, 3'b011, 4'h0, LCE};
      c.data = d;
      return c;
   endfunction

   // Responder: accepts commands, checks them against the queue, returns one response each.
   bit            pend = 0, pend_stat = 0, yumi_seen = 0, held = 0, prev_v = 0;
   int            delay = 0;
   cmd_t          held_cmd, e;
   logic [HW-1:0] pend_hdr;
   logic [63:0]   pend_data;
   longint        cyc = 0, last_stat = -1;

   initial begin
      io_cmd_ready_and_i = 1'b0;
      io_resp_v_i = 1'b0; io_resp_header_i = '0; io_resp_data_i = '0;
      forever begin
         @(negedge clk); #2; cyc++;
         if (yumi_seen) begin
            io_resp_v_i = 1'b0; io_resp_header_i = '0; io_resp_data_i = '0;
            pend = 0; yumi_seen = 0; n_resp_done++;
         end
         if (pend && !io_resp_v_i && !(hold_stat && pend_stat)) begin
            if (delay == 0) begin
               io_resp_v_i = 1'b1; io_resp_header_i = pend_hdr; io_resp_data_i = pend_data;
            end else delay--;
         end
         if (held) begin
            chk("cmd_v_held", io_cmd_v_o, 1'b1);
            chk("cmd_hdr_stable", io_cmd_header_o, held_cmd.hdr);
            chk("cmd_data_stable", io_cmd_data_o, held_cmd.data);
         end
         if (io_cmd_v_o && !prev_v && io_cmd_header_o[HW-9 -: PA] == stat_addr && last_stat >= 0) begin
            n_checks++;
            if (cyc - last_stat - 1 < GAP) begin
               n_fail++;
               $display("FAIL poll_gap: %0d idle cycles, required >= %0d", cyc - last_stat - 1, GAP);
            end
         end
         prev_v = io_cmd_v_o;
         io_cmd_ready_and_i = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
         held = 0;
         if (io_cmd_v_o && io_cmd_ready_and_i) begin
            n_checks++;
            if (pend) begin
               n_fail++;
               $display("FAIL two_outstanding: new command while a response is pending");
            end
            n_checks++;
            if (exp_cmd_q.size() == 0) begin
               n_fail++;
               $display("FAIL cmd_unexpected: hdr %h data %h, required no command", io_cmd_header_o, io_cmd_data_o);
            end else begin
               n_checks--;
               e = exp_cmd_q.pop_front();
               chk("cmd_hdr", io_cmd_header_o, e.hdr);
               chk("cmd_data", io_cmd_data_o, e.data);
            end
            pend      = 1;
            pend_stat = (io_cmd_header_o[HW-9 -: PA] == stat_addr);
            delay     = bp_mode ? int'($urandom_range(0, 10)) : 0;
            pend_hdr  = {io_cmd_header_o[HW-1 -: 4], 4'h0, io_cmd_header_o[HW-9 -: PA], 3'b011, 4'h0, 8'h00};
            pend_data = '0;
            if (pend_stat) begin
               n_stat_fire++;
               if (stat_q.size() != 0) pend_data = stat_q.pop_front();
            end else begin
               last_stat = -1;
               if (io_cmd_header_o[HW-9 -: PA] == res_addr && res_data_q.size() != 0)
                  pend_data = res_data_q.pop_front();
            end
         end else if (io_cmd_v_o) begin
            held = 1;
            held_cmd.hdr  = io_cmd_header_o;
            held_cmd.data = io_cmd_data_o;
         end
         #1;
         yumi_seen = io_resp_v_i && io_resp_yumi_o;
         if (yumi_seen && pend_stat) last_stat = cyc;
      end
   end

   // Result monitor
   res_t r;
   initial forever begin
      @(negedge clk); #2;
      if (result_v_o && result_yumi_i) begin
         if (exp_res_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL result_unexpected: result %h err %b, required none", result_o, result_err_o);
         end else begin
            r = exp_res_q.pop_front();
            chk("result_val", result_o, r.val);
            chk("result_err", result_err_o, r.err);
         end
      end
   end

   task automatic submit_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] len);
      int w = 0;
      while (!job_ready_and_o && w < 200) begin @(negedge clk); w++; end
      n_checks++;
      if (!job_ready_and_o) begin
         n_fail++;
         $display("FAIL job_ready_timeout: job_ready_and_o=0 after %0d cycles, required 1", w);
      end
      job_v_i = 1'b1; job_a_i = a; job_b_i = b; job_len_i = len;
      @(negedge clk);
      job_v_i = 1'b0;
      chk("job_accepted", job_ready_and_o, 1'b0);
   endtask

   task automatic run_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] len,
                          input int nzero, input logic [63:0] stat_nz, input logic [63:0] res,
                          input bit timeout);
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h00, a));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h08, b));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h10, len));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h18, 64'd1));
      if (timeout) begin
         for (int i = 0; i < LIMIT; i++) begin
            exp_cmd_q.push_back(mk_cmd(UC_RD, 8'h20, 64'd0));
            stat_q.push_back(64'd0);
         end
         exp_res_q.push_back('{val: 64'd0, err: 1'b1});
      end else begin
         for (int i = 0; i < nzero; i++) begin
            exp_cmd_q.push_back(mk_cmd(UC_RD, 8'h20, 64'd0));
            stat_q.push_back(64'd0);
         end
         exp_cmd_q.push_back(mk_cmd(UC_RD, 8'h20, 64'd0));
         stat_q.push_back(stat_nz);
         exp_cmd_q.push_back(mk_cmd(UC_RD, 8'h28, 64'd0));
         res_data_q.push_back(res);
         exp_res_q.push_back('{val: res, err: 1'b0});
      end
      submit_job(a, b, len);
   endtask

   task automatic collect_result(input int hold);
      int w = 0;
      logic [63:0] sv;
      while (!result_v_o && w < 3000) begin @(negedge clk); w++; end
      if (!result_v_o) begin
         n_checks++; n_fail++;
         $display("FAIL result_timeout: result_v_o=0 after %0d cycles, required 1", w);
         return;
      end
      sv = result_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_result_v", result_v_o, 1'b1);
         chk("hold_result_o", result_o, sv);
         chk("hold_job_ready", job_ready_and_o, 1'b0);
      end
      result_yumi_i = 1'b1;
      @(negedge clk);
      result_yumi_i = 1'b0;
      chk("cmd_queue_drained", exp_cmd_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, r0, s0;
      stat_addr = BASE[PA-1:0] + 40'h20;
      res_addr  = BASE[PA-1:0] + 40'h28;
      reset_i = 1'b1; job_v_i = 1'b0; job_a_i = '0; job_b_i = '0; job_len_i = '0; result_yumi_i = 1'b0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      chk("rst_cmd_v", io_cmd_v_o, 1'b0);
      chk("rst_cmd_hdr", io_cmd_header_o, '0);
      chk("rst_cmd_data", io_cmd_data_o, '0);
      chk("rst_resp_yumi", io_resp_yumi_o, 1'b0);
      chk("rst_result_v", result_v_o, 1'b0);
      chk("rst_result", result_o, '0);
      chk("rst_result_err", result_err_o, 1'b0);
      chk("rst_job_ready", job_ready_and_o, 1'b1);

      // Basic job
      run_job(64'h1000, 64'h2000, 64'd4, 0, 64'd1, 64'h2A, 0);
      collect_result(0);
      // Delayed done: three zero polls then 5
      run_job(64'h3000, 64'h4000, 64'd16, 3, 64'd5, 64'h1234_5678_9ABC_DEF0, 0);
      collect_result(0);
      // Timeout: status always zero
      run_job(64'h5000, 64'h6000, 64'd8, 0, 64'd0, 64'd0, 1);
      collect_result(0);
      // Backpressure on commands and delayed responses
      bp_mode = 1;
      run_job(64'h1000, 64'h2000, 64'd4, 0, 64'd1, 64'h2A, 0);
      collect_result(0);
      bp_mode = 0;
      // Result held 20 cycles, then a back-to-back job
      run_job(64'h7000, 64'h8000, 64'd2, 1, 64'd3, 64'hCAFE, 0);
      collect_result(20);
      chk("b2b_job_ready", job_ready_and_o, 1'b1);
      run_job(64'h1000, 64'h2000, 64'd4, 0, 64'd1, 64'h2A, 0);
      collect_result(0);

      // Reset while waiting for a status response
      hold_stat = 1;
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h00, 64'h9000));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h08, 64'hA000));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h10, 64'd32));
      exp_cmd_q.push_back(mk_cmd(UC_WR, 8'h18, 64'd1));
      exp_cmd_q.push_back(mk_cmd(UC_RD, 8'h20, 64'd0));
      stat_q.push_back(64'h77);
      s0 = n_stat_fire;
      submit_job(64'h9000, 64'hA000, 64'd32);
      w = 0;
      while (n_stat_fire == s0 && w < 200) begin @(negedge clk); w++; end
      chk("mid_status_read_issued", n_stat_fire, s0 + 1);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("mid_rst_cmd_v", io_cmd_v_o, 1'b0);
      chk("mid_rst_cmd_hdr", io_cmd_header_o, '0);
      chk("mid_rst_cmd_data", io_cmd_data_o, '0);
      chk("mid_rst_resp_yumi", io_resp_yumi_o, 1'b0);
      chk("mid_rst_result_v", result_v_o, 1'b0);
      chk("mid_rst_result", result_o, '0);
      chk("mid_rst_result_err", result_err_o, 1'b0);
      chk("mid_rst_job_ready", job_ready_and_o, 1'b1);
      r0 = n_resp_done;
      hold_stat = 0;
      w = 0;
      while (n_resp_done == r0 && w < 50) begin @(negedge clk); w++; end
      chk("late_resp_yumid", n_resp_done, r0 + 1);
      repeat (3) @(negedge clk);
      chk("late_resp_dropped_cmd_v", io_cmd_v_o, 1'b0);
      chk("late_resp_dropped_result_v", result_v_o, 1'b0);
      chk("late_resp_dropped_idle", job_ready_and_o, 1'b1);
      chk("mid_rst_cmd_queue", exp_cmd_q.size(), 0);

      run_job(64'hB000, 64'hC000, 64'd6, 1, 64'd9, 64'h5555_AAAA, 0);
      collect_result(0);

      repeat (5) @(negedge clk);
      chk("final_res_queue", exp_res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
